// File: rtl/mem_lsu_if.sv
// mem_lsu_if: EX-side issue, data-memory bus and writeback signals of the load/store unit
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_mem;
  logic              in_is_store;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_ex_result;
  logic              in_rf_we;
  logic [4:0]        in_rf_waddr;
  logic [31:0]       in_pc;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W/8-1:0] dmem_wstrb;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic              out_rf_we;
  logic [4:0]        out_rf_waddr;
  logic [DATA_W-1:0] out_rf_wdata;
  logic              out_misalign;
  logic              stall_req;

  modport master (
    output in_valid, in_is_mem, in_is_store, in_size, in_unsigned, in_addr, in_wdata,
           in_ex_result, in_rf_we, in_rf_waddr, in_pc, dmem_req_ready, dmem_resp_valid, dmem_rdata,
    input  in_ready, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
           out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata, out_misalign, stall_req
  );

  modport slave (
    input  in_valid, in_is_mem, in_is_store, in_size, in_unsigned, in_addr, in_wdata,
           in_ex_result, in_rf_we, in_rf_waddr, in_pc, dmem_req_ready, dmem_resp_valid, dmem_rdata,
    output in_ready, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
           out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata, out_misalign, stall_req
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit issuing one aligned access at a time and returning results to writeback
module mem_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  mem_lsu_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int DL = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t r_state, w_next;

  logic              r_is_store, r_unsigned, r_rf_we;
  logic [1:0]        r_size;
  logic [OW-1:0]     r_off;
  logic [4:0]        r_rf_waddr;
  logic [31:0]       r_pc;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [NB-1:0]     r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic              r_out_valid, r_out_rf_we, r_out_misalign;
  logic [31:0]       r_out_pc;
  logic [4:0]        r_out_rf_waddr;
  logic [DATA_W-1:0] r_out_rf_wdata;

  logic              w_accept, w_mis, w_done_st, w_done_ld;
  logic [OW-1:0]     w_off, w_lane;
  logic [15:0]       w_strb16;
  logic [DATA_W-1:0] w_rep, w_sh, w_keep, w_load;
  logic [6:0]        w_nb;
  logic [DL-1:0]     w_msb;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_off     = bus.in_addr[OW-1:0];
  assign w_mis     = (bus.in_size == 2'd1 && bus.in_addr[0]) ||
                     (bus.in_size == 2'd2 && bus.in_addr[1:0] != 2'd0) ||
                     (bus.in_size == 2'd3 && (DATA_W == 32 || bus.in_addr[2:0] != 3'd0));
  assign w_strb16  = ((16'd1 << (5'd1 << bus.in_size)) - 16'd1) << w_off;
  assign w_lane    = OW'((4'd1 << bus.in_size) - 4'd1);
  assign w_done_st = r_state == REQ && bus.dmem_req_ready && r_is_store;
  assign w_done_ld = r_state == WAIT && bus.dmem_resp_valid;

  // Store data: each byte lane takes the matching byte of the low element, repeating it across the bus
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < NB; i++) w_rep[8*i +: 8] = bus.in_wdata[{OW'(i) & w_lane, 3'b000} +: 8];
  end

  // Load data: shift the addressed element down, keep its width, then sign- or zero-fill the rest
  assign w_sh   = bus.dmem_rdata >> {r_off, 3'b000};
  assign w_nb   = 7'd8 << r_size;
  assign w_msb  = w_nb[DL-1:0] - DL'(1);
  assign w_keep = ~({DATA_W{1'b1}} << w_nb);
  assign w_load = (w_sh & w_keep) | ({DATA_W{~r_unsigned & w_sh[w_msb]}} & ~w_keep);

  // State register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

  // Next state: only aligned memory ops leave IDLE; stores finish on the handshake, loads wait for data
  always_comb begin
    w_next = r_state == IDLE ? ((w_accept && bus.in_is_mem && !w_mis) ? REQ : IDLE)
           : r_state == REQ  ? (bus.dmem_req_ready ? (r_is_store ? IDLE : WAIT) : REQ)
           : (bus.dmem_resp_valid ? IDLE : WAIT);
  end

  // FSM outputs
  always_comb begin
    bus.in_ready       = r_state == IDLE;
    bus.stall_req      = r_state != IDLE;
    bus.dmem_req_valid = r_state == REQ;
  end

  assign bus.dmem_we      = r_is_store;
  assign bus.dmem_addr    = r_dmem_addr;
  assign bus.dmem_wstrb   = r_wstrb;
  assign bus.dmem_wdata   = r_wdata;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_rf_we    = r_out_rf_we;
  assign bus.out_rf_waddr = r_out_rf_waddr;
  assign bus.out_rf_wdata = r_out_rf_wdata;
  assign bus.out_misalign = r_out_misalign;

  // Capture the accepted op and build the writeback pulse; bus fields freeze while the request is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store     <= 1'b0;
      r_unsigned     <= 1'b0;
      r_rf_we        <= 1'b0;
      r_size         <= 2'd0;
      r_off          <= '0;
      r_rf_waddr     <= 5'd0;
      r_pc           <= 32'd0;
      r_dmem_addr    <= '0;
      r_wstrb        <= '0;
      r_wdata        <= '0;
      r_out_valid    <= 1'b0;
      r_out_rf_we    <= 1'b0;
      r_out_misalign <= 1'b0;
      r_out_pc       <= 32'd0;
      r_out_rf_waddr <= 5'd0;
      r_out_rf_wdata <= '0;
    end else begin
      r_out_valid    <= 1'b0;
      r_out_misalign <= 1'b0;
      if (w_accept) begin
        r_is_store  <= bus.in_is_store;
        r_unsigned  <= bus.in_unsigned;
        r_rf_we     <= bus.in_rf_we;
        r_size      <= bus.in_size;
        r_off       <= w_off;
        r_rf_waddr  <= bus.in_rf_waddr;
        r_pc        <= bus.in_pc;
        r_dmem_addr <= {bus.in_addr[ADDR_W-1:OW], OW'(0)};
        r_wstrb     <= bus.in_is_store ? w_strb16[NB-1:0] : '0;
        r_wdata     <= w_rep;
      end
      if (w_accept && (!bus.in_is_mem || w_mis)) begin
        r_out_valid    <= 1'b1;
        r_out_misalign <= bus.in_is_mem;
        r_out_rf_we    <= !bus.in_is_mem && bus.in_rf_we;
        r_out_pc       <= bus.in_pc;
        r_out_rf_waddr <= bus.in_rf_waddr;
        r_out_rf_wdata <= bus.in_is_mem ? r_out_rf_wdata : bus.in_ex_result;
      end
      if (w_done_st || w_done_ld) begin
        r_out_valid    <= 1'b1;
        r_out_rf_we    <= w_done_ld && r_rf_we;
        r_out_pc       <= r_pc;
        r_out_rf_waddr <= r_rf_waddr;
        r_out_rf_wdata <= w_done_ld ? w_load : r_out_rf_wdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors driving a 32-bit and a 64-bit load/store unit in lockstep
module tb_mem_lsu;
  logic clk, rst;
  logic in_valid, is_mem, is_store, uns, rf_we, req_ready, resp_valid;
  logic [1:0]  size;
  logic [31:0] addr, pc, rd32;
  logic [63:0] wdata, ex, rd64;
  logic [4:0]  waddr;
  int n_chk, n_err;

  mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  assign b32.in_valid = in_valid;   assign b64.in_valid = in_valid;
  assign b32.in_is_mem = is_mem;    assign b64.in_is_mem = is_mem;
  assign b32.in_is_store = is_store; assign b64.in_is_store = is_store;
  assign b32.in_size = size;        assign b64.in_size = size;
  assign b32.in_unsigned = uns;     assign b64.in_unsigned = uns;
  assign b32.in_addr = addr;        assign b64.in_addr = addr;
  assign b32.in_wdata = wdata[31:0]; assign b64.in_wdata = wdata;
  assign b32.in_ex_result = ex[31:0]; assign b64.in_ex_result = ex;
  assign b32.in_rf_we = rf_we;      assign b64.in_rf_we = rf_we;
  assign b32.in_rf_waddr = waddr;   assign b64.in_rf_waddr = waddr;
  assign b32.in_pc = pc;            assign b64.in_pc = pc;
  assign b32.dmem_req_ready = req_ready; assign b64.dmem_req_ready = req_ready;
  assign b32.dmem_resp_valid = resp_valid; assign b64.dmem_resp_valid = resp_valid;
  assign b32.dmem_rdata = rd32;     assign b64.dmem_rdata = rd64;

  mem_lsu #(.DATA_W(32), .ADDR_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  mem_lsu #(.DATA_W(64), .ADDR_W(32)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic st, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] exv,
                       input logic [4:0] rd);
    is_mem = m; is_store = st; size = sz; uns = u; addr = a; wdata = wd; ex = exv;
    waddr = rd; rf_we = !st; pc = 32'h400 + a;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic handshake;
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] r32, input logic [63:0] r64);
    rd32 = r32; rd64 = r64; resp_valid = 1'b1;
    tick;
    resp_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    in_valid = 0; is_mem = 0; is_store = 0; uns = 0; rf_we = 0; req_ready = 0; resp_valid = 0;
    size = 0; addr = 0; pc = 0; rd32 = 0; wdata = 0; ex = 0; rd64 = 0; waddr = 0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", b32.in_ready, 1);
    chk("rst_stall", b32.stall_req, 0);
    chk("rst_valid", b32.out_valid, 0);
    chk("rst_req", b32.dmem_req_valid, 0);

    issue(0, 0, 0, 0, 32'h0, 0, 64'h1234, 5);
    chk("nm_valid", b32.out_valid, 1);
    chk("nm_wdata", b32.out_rf_wdata, 64'h1234);
    chk("nm_waddr", b32.out_rf_waddr, 5);
    chk("nm_we", b32.out_rf_we, 1);
    chk("nm_pc", b32.out_pc, 32'h400);
    chk("nm_mis", b32.out_misalign, 0);
    tick;
    chk("nm_pulse", b32.out_valid, 0);
    chk("nm_hold", b32.out_rf_wdata, 64'h1234);

    issue(1, 0, 0, 0, 32'h103, 0, 0, 7);
    chk("lb_req", b32.dmem_req_valid, 1);
    chk("lb_addr", b32.dmem_addr, 32'h100);
    chk("lb_strb", b32.dmem_wstrb, 0);
    chk("lb_stall", b32.stall_req, 1);
    chk("lb_inrdy", b32.in_ready, 0);
    handshake;
    chk("lb_wait_req", b32.dmem_req_valid, 0);
    chk("lb_wait_valid", b32.out_valid, 0);
    respond(32'h80FF_0000, 0);
    chk("lb_valid", b32.out_valid, 1);
    chk("lb_data", b32.out_rf_wdata, 32'hFFFF_FF80);
    chk("lb_waddr", b32.out_rf_waddr, 7);

    issue(1, 0, 0, 1, 32'h103, 0, 0, 7);
    handshake;
    respond(32'h80FF_0000, 0);
    chk("lbu_data", b32.out_rf_wdata, 32'h0000_0080);

    issue(1, 1, 1, 0, 32'h102, 64'hABCD, 0, 0);
    chk("sh64_strb", b64.dmem_wstrb, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      chk("sh_strb", b32.dmem_wstrb, 4'b1100);
      chk("sh_wdata", b32.dmem_wdata, 32'hABCD_ABCD);
      chk("sh_stall", b32.stall_req, 1);
      chk("sh_req", b32.dmem_req_valid, 1);
      tick;
    end
    chk("sh_we_bus", b32.dmem_we, 1);
    handshake;
    chk("sh_valid", b32.out_valid, 1);
    chk("sh_rfwe", b32.out_rf_we, 0);
    chk("sh_done_stall", b32.stall_req, 0);

    issue(1, 0, 2, 0, 32'h101, 0, 0, 3);
    chk("mis_flag", b32.out_misalign, 1);
    chk("mis_valid", b32.out_valid, 1);
    chk("mis_rfwe", b32.out_rf_we, 0);
    chk("mis_req", b32.dmem_req_valid, 0);
    tick;
    chk("mis_pulse", b32.out_misalign, 0);
    chk("mis_req2", b32.dmem_req_valid, 0);

    issue(1, 0, 3, 0, 32'h8, 0, 0, 9);
    chk("ld32_mis", b32.out_misalign, 1);
    chk("ld_req", b64.dmem_req_valid, 1);
    chk("ld_addr", b64.dmem_addr, 32'h8);
    handshake;
    respond(0, 64'h1122_3344_5566_7788);
    chk("ld_valid", b64.out_valid, 1);
    chk("ld_data", b64.out_rf_wdata, 64'h1122_3344_5566_7788);

    issue(1, 0, 2, 0, 32'hC, 0, 0, 10);
    chk("lw64_addr", b64.dmem_addr, 32'h8);
    handshake;
    respond(32'hFFFF_FFFE, 64'h1122_3344_5566_7788);
    chk("lw64_data", b64.out_rf_wdata, 64'h0000_0000_1122_3344);
    chk("lw32_data", b32.out_rf_wdata, 32'hFFFF_FFFE);

    issue(1, 0, 2, 0, 32'h10, 0, 0, 11);
    rd32 = 32'h55; resp_valid = 1'b1; req_ready = 1'b1;
    tick;
    resp_valid = 1'b0; req_ready = 1'b0;
    chk("rr_novalid", b32.out_valid, 0);
    chk("rr_wait_stall", b32.stall_req, 1);
    chk("rr_wait_req", b32.dmem_req_valid, 0);
    respond(32'h55, 0);
    chk("rr_valid", b32.out_valid, 1);
    chk("rr_data", b32.out_rf_wdata, 32'h55);

    issue(1, 0, 2, 0, 32'h200, 0, 0, 12);
    handshake;
    chk("ab_stall", b32.stall_req, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("ab_ready", b32.in_ready, 1);
    chk("ab_stall0", b32.stall_req, 0);
    chk("ab_wdata0", b32.out_rf_wdata, 0);
    respond(32'h77, 64'h77);
    chk("ab_novalid", b32.out_valid, 0);
    chk("ab_novalid64", b64.out_valid, 0);
    tick;
    chk("ab_novalid2", b32.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_W, default 32, data path and register width (32 or 64).
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  EX stage presents an instruction.
REQ-006 in_ready  output  1  block accepts the instruction this cycle.
REQ-007 in_is_mem, in_is_store  input  1 each  memory op; store (else load).
REQ-008 in_size  input  2  0 byte, 1 half, 2 word, 3 dword.
REQ-009 in_unsigned  input  1  zero-extend load result (else sign-extend).
REQ-010 in_addr  input  ADDR_W  effective byte address.
REQ-011 in_wdata, in_ex_result  input  DATA_W each  store data; ALU result.
REQ-012 in_rf_we, in_rf_waddr, in_pc  input  1/5/32  writeback control and PC.
REQ-013 dmem_req_valid, dmem_req_ready  output/input  1 each  bus request handshake.
REQ-014 dmem_we, dmem_addr, dmem_wstrb, dmem_wdata  output  1/ADDR_W/DATA_W/8/DATA_W  bus request fields.
REQ-015 dmem_resp_valid, dmem_rdata  input  1/DATA_W  load response.
REQ-016 out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata  output  1/32/1/5/DATA_W  WB bus.
REQ-017 out_misalign  output  1  misaligned-access exception pulse.
REQ-018 stall_req  output  1  stall request to pipeline control.

Function
REQ-019 The block SHALL implement states IDLE, REQ, WAIT; in_ready = stall_req inverted = (state==IDLE).
REQ-020 Accept = in_valid && in_ready; accepted fields SHALL be captured into internal registers.
REQ-021 Non-memory op SHALL produce out_valid=1 next cycle with out_rf_wdata=in_ex_result, state stays IDLE.
REQ-022 Misaligned: half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0; size 3 with DATA_W=32 SHALL count as misaligned.
REQ-023 Misaligned mem op SHALL give out_valid=1, out_misalign=1, out_rf_we=0 next cycle, no bus request, state IDLE.
REQ-024 Aligned mem op SHALL enter REQ; dmem_req_valid=1 with all dmem fields stable until dmem_req_ready=1.
REQ-025 Byte offset off = addr[log2(DATA_W/8)-1:0]; dmem_addr = in_addr with offset bits cleared.
REQ-026 dmem_wstrb = ((1<<(1<<size))-1) << off for stores, all zero for loads.
REQ-027 dmem_wdata = low (8<<size) bits of in_wdata replicated across all lanes.
REQ-028 Store handshake SHALL return to IDLE and pulse out_valid=1, out_rf_we=0 next cycle.
REQ-029 Load handshake SHALL enter WAIT; dmem_resp_valid in WAIT returns to IDLE, pulses out_valid next cycle.
REQ-030 Load data = (dmem_rdata >> 8*off) truncated to 8<<size bits, sign/zero-extended to DATA_W per in_unsigned.
REQ-031 dmem_resp_valid SHALL be ignored in IDLE and REQ; ready and resp in same cycle of REQ only completes the request phase.
REQ-032 out_valid SHALL be a single-cycle pulse; out_* fields hold last values when out_valid=0.
REQ-033 Latency: non-mem/misaligned 1 cycle; store with ready in first REQ cycle 2 cycles; load = resp cycle + 1.

Reset
REQ-034 rst SHALL force state IDLE, all outputs 0 (in_ready=1, stall_req=0) on the next edge, including mid-REQ/WAIT.
REQ-035 A response arriving after reset SHALL be discarded; no out_valid results from an aborted access.

Verification
REQ-036 Non-mem, in_ex_result=0x1234, rd=5 -> next cycle out_valid=1, out_rf_wdata=0x1234, out_rf_waddr=5.
REQ-037 DATA_W=32 lb addr 0x103, rdata 0x80FF_0000 -> out_rf_wdata=0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-038 sh addr 0x102, wdata 0xABCD, ready delayed 3 cycles -> wstrb=4'b1100, wdata=0xABCD_ABCD stable, stall_req=1 throughout.
REQ-039 lw addr 0x101 -> out_misalign=1, out_rf_we=0, dmem_req_valid never asserted.
REQ-040 DATA_W=64 ld addr 0x8, rdata 0x1122_3344_5566_7788 -> out_rf_wdata identical; lw addr 0xC -> 0x0000_0000_1122_3344.
REQ-041 rst asserted in WAIT, resp one cycle later -> state IDLE, out_valid stays 0.
